mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the bits per word.
REQ-002 The module SHALL have parameter BANKING_FACTOR, default 1, giving the words per beat.
REQ-003 The module SHALL have parameter ADDRESS_WIDTH, default 13, giving the beat address width.
REQ-004 The module SHALL have parameter MEM_LATENCY, default 3 (legal 1..8), giving the fixed read latency.
REQ-005 The module SHALL have parameter DEPTH, default 64, giving the number of stored beats; legal addresses are 0..DEPTH-1.
REQ-006 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 Port mem_req_addr, input, ADDRESS_WIDTH bits: beat address.
REQ-009 Port mem_req_data, input, BANKING_FACTOR*DATA_WIDTH bits: write beat; word b is bits [b*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Port mem_read_en, input, 1 bit: read request, sampled each edge.
REQ-011 Port mem_write_en, input, 1 bit: write request, sampled each edge.
REQ-012 Port mem_resp_data, output, BANKING_FACTOR*DATA_WIDTH bits: registered read data.
REQ-013 Port mem_resp_valid, output, 1 bit: one-cycle pulse marking a new response.
REQ-014 Port err, output, 1 bit: sticky error flag.
REQ-015 Port rd_count, output, 16 bits: accepted-read counter, saturating.
REQ-016 Port wr_count, output, 16 bits: accepted-write counter, saturating.

Function
REQ-017 Storage SHALL be DEPTH beats of BANKING_FACTOR*DATA_WIDTH bits, with no handshake and no backpressure; requests are accepted every cycle.
REQ-018 A write sampled at edge k with an address below DEPTH SHALL update the beat at edge k.
REQ-019 A read sampled at any edge after edge k SHALL return the data written at edge k.
REQ-020 A read sampled at edge k SHALL drive mem_resp_data and pulse mem_resp_valid from edge k+MEM_LATENCY-1; MEM_LATENCY=1 means the response appears at edge k.
REQ-021 Read data SHALL travel through a valid/data pipeline MEM_LATENCY-1 stages deep, so back-to-back reads every cycle each produce one response, in order.
REQ-022 mem_resp_data SHALL hold its last response value until the next response; it SHALL NOT return to zero between responses.
REQ-023 When mem_read_en and mem_write_en are sampled high together, the write SHALL be performed and the read SHALL be dropped (no response), and err SHALL be set.
REQ-024 A read with address >= DEPTH SHALL respond normally in timing with an all-zero beat and SHALL set err.
REQ-025 A write with address >= DEPTH SHALL be discarded and SHALL set err.
REQ-026 rd_count SHALL increment per accepted read, including out-of-range reads but excluding dropped reads.
REQ-027 wr_count SHALL increment per write sampled, including out-of-range writes.
REQ-028 Both counters SHALL saturate at 16'hFFFF.
REQ-029 err SHALL stay set until reset.
REQ-030 Width rules: addresses SHALL be compared unsigned at full ADDRESS_WIDTH, and no truncation to log2(DEPTH) is permitted before the range check.

Reset
REQ-031 While rst is high, mem_resp_data, mem_resp_valid, err, rd_count, wr_count, the pipeline valid bits and all storage beats SHALL be 0.
REQ-032 Asserting rst mid-read SHALL immediately cancel in-flight responses; no mem_resp_valid pulse SHALL follow for requests sampled before rst.
REQ-033 Requests SHALL be ignored while rst is high.
REQ-034 The first request SHALL be sampled at the first rising edge after rst falls.

Verification (MEM_LATENCY=3, BANKING_FACTOR=1, DEPTH=64)
REQ-035 Write 0xDEADBEEF to addr 5 at edge 0, then read addr 5 at edge 1 -> mem_resp_valid pulses at edge 3, mem_resp_data=0xDEADBEEF held afterwards; wr_count=1, rd_count=1.
REQ-036 Write addrs 0..15 with value addr+100, then read 0..15 on consecutive cycles -> 16 consecutive valid pulses carrying 100..115 in order, err=0.
REQ-037 Read and write addr 7 with value 0x55 in the same cycle -> no response pulse, a later read of 7 returns 0x55, err=1, rd_count unchanged.
REQ-038 Read addr 64 -> response pulse with data 0 at latency 3, err=1; write addr 100 -> storage unchanged, err stays 1.
REQ-039 Issue a read, then assert rst one cycle later -> no mem_resp_valid, all outputs 0; after release, reading the previously written addr returns 0.
REQ-040 Force rd_count to 16'hFFFF via 65535 reads, then issue one more read -> rd_count stays 16'hFFFF.

Source files
------------

// File: rtl/mem_responder_if.sv
// mem_responder_if -- request/response bundle for mem_responder.
//
// Request side (driven by the master):
//   mem_req_addr   beat address
//   mem_req_data   write beat, word b at [b*DATA_WIDTH +: DATA_WIDTH]
//   mem_read_en    read request, sampled every rising edge
//   mem_write_en   write request, sampled every rising edge
// Response side (driven by the slave):
//   mem_resp_data  last read response, held between responses
//   mem_resp_valid one-cycle pulse per response
//   err            sticky error flag
//   rd_count       accepted reads, saturating at 16'hFFFF
//   wr_count       sampled writes, saturating at 16'hFFFF
interface mem_responder_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int BANKING_FACTOR = 1,
  parameter int ADDRESS_WIDTH  = 13
) ();
  logic [ADDRESS_WIDTH-1:0]             mem_req_addr;
  logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_req_data;
  logic                                 mem_read_en;
  logic                                 mem_write_en;
  logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_resp_data;
  logic                                 mem_resp_valid;
  logic                                 err;
  logic [15:0]                          rd_count;
  logic [15:0]                          wr_count;

  modport master (
    output mem_req_addr, mem_req_data, mem_read_en, mem_write_en,
    input  mem_resp_data, mem_resp_valid, err, rd_count, wr_count
  );

  modport slave (
    input  mem_req_addr, mem_req_data, mem_read_en, mem_write_en,
    output mem_resp_data, mem_resp_valid, err, rd_count, wr_count
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder -- fixed-latency memory model with no backpressure.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; clears storage, pipeline and flags
//   bus  mem_responder_if.slave (request in, response/status out)
//
// A read sampled at edge k is looked up combinationally and captured in
// stage 0 at edge k, then shifted through MEM_LATENCY-1 further stages, so
// the response is visible from edge k+MEM_LATENCY-1. Storage is held in
// resettable registers because every beat must read as zero after reset.
module mem_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int BANKING_FACTOR = 1,
  parameter int ADDRESS_WIDTH  = 13,
  parameter int MEM_LATENCY    = 3,
  parameter int DEPTH          = 64
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int BEAT_W = DATA_WIDTH * BANKING_FACTOR;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BEAT_W-1:0]      mem_reg        [DEPTH];
  logic [BEAT_W-1:0]      pipe_data_reg  [MEM_LATENCY];
  logic [MEM_LATENCY-1:0] pipe_valid_reg;
  logic                   err_reg;
  logic [15:0]            rd_count_reg;
  logic [15:0]            wr_count_reg;

  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              rd_accept;
  logic              wr_fire;
  logic [BEAT_W-1:0] rd_beat;
  logic              err_next;

  // Range check on the full address; the narrowed index is only used once
  // the address is known to be in range.
  assign in_range  = (64'(bus.mem_req_addr) < 64'(DEPTH));
  assign idx       = bus.mem_req_addr[IDX_W-1:0];
  assign wr_fire   = bus.mem_write_en;
  // A simultaneous write wins; the read is dropped entirely.
  assign rd_accept = bus.mem_read_en & ~bus.mem_write_en;
  assign rd_beat   = in_range ? mem_reg[idx] : '0;

  assign err_next = (bus.mem_read_en & bus.mem_write_en)
                  | (bus.mem_read_en & ~in_range)
                  | (bus.mem_write_en & ~in_range);

  // One register bank per beat.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_beat
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem_reg[gi] <= '0;
      end else if (wr_fire && in_range && (idx == IDX_W'(gi))) begin
        mem_reg[gi] <= bus.mem_req_data;
      end
    end
  end

  // Stage 0 captures the lookup. Data only moves alongside a valid bit, so
  // the final stage holds the last response between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid_reg[0] <= 1'b0;
      pipe_data_reg[0]  <= '0;
    end else begin
      pipe_valid_reg[0] <= rd_accept;
      if (rd_accept) begin
        pipe_data_reg[0] <= rd_beat;
      end
    end
  end

  for (genvar gi = 1; gi < MEM_LATENCY; gi++) begin : g_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_valid_reg[gi] <= 1'b0;
        pipe_data_reg[gi]  <= '0;
      end else begin
        pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
        if (pipe_valid_reg[gi-1]) begin
          pipe_data_reg[gi] <= pipe_data_reg[gi-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg      <= 1'b0;
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else begin
      if (err_next) begin
        err_reg <= 1'b1;
      end
      if (rd_accept && (rd_count_reg != 16'hFFFF)) begin
        rd_count_reg <= rd_count_reg + 16'd1;
      end
      if (wr_fire && (wr_count_reg != 16'hFFFF)) begin
        wr_count_reg <= wr_count_reg + 16'd1;
      end
    end
  end

  assign bus.mem_resp_valid = pipe_valid_reg[MEM_LATENCY-1];
  assign bus.mem_resp_data  = pipe_data_reg[MEM_LATENCY-1];
  assign bus.err            = err_reg;
  assign bus.rd_count       = rd_count_reg;
  assign bus.wr_count       = wr_count_reg;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder -- randomized and directed stimulus with a scoreboard.
// The driver updates an array-based reference model and queues expected
// responses with their due edge; a negedge monitor pops and compares.
module tb_mem_responder;
  localparam int DW = 32;
  localparam int BF = 1;
  localparam int AW = 13;
  localparam int LAT = 3;
  localparam int DEP = 64;

  logic clk;
  logic rst;
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  mem_responder_if #(.DATA_WIDTH(DW), .BANKING_FACTOR(BF), .ADDRESS_WIDTH(AW)) bus ();

  mem_responder #(
    .DATA_WIDTH(DW), .BANKING_FACTOR(BF), .ADDRESS_WIDTH(AW),
    .MEM_LATENCY(LAT), .DEPTH(DEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model
  logic [31:0] mdl [DEP];
  bit          m_err;
  int          m_rd;
  int          m_wr;
  logic [31:0] exp_q [$];
  int          due_q [$];
  logic [31:0] last_resp = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest expectation and its due edge;
  // between responses the data must hold.
  always @(negedge clk) begin
    logic [31:0] e;
    int d;
    if (bus.mem_resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got pulse with data %0h expected no response", bus.mem_resp_data);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        chk("resp_data", 64'(bus.mem_resp_data), 64'(e));
        chk("resp_edge", 64'(edge_cnt), 64'(d));
        last_resp = e;
      end
    end else begin
      chk("resp_hold", 64'(bus.mem_resp_data), 64'(last_resp));
    end
  end

  task automatic req(input bit rd, input bit wr, input int addr, input logic [31:0] data);
    bit in_rng;
    @(negedge clk);
    bus.mem_read_en  = rd;
    bus.mem_write_en = wr;
    bus.mem_req_addr = AW'(addr);
    bus.mem_req_data = data;
    @(posedge clk);
    #1;
    in_rng = (addr < DEP);
    if (rd && wr) m_err = 1'b1;
    if (wr) begin
      if (in_rng) mdl[addr] = data;
      else m_err = 1'b1;
      if (m_wr < 65535) m_wr++;
    end else if (rd) begin
      if (!in_rng) m_err = 1'b1;
      exp_q.push_back(in_rng ? mdl[addr] : 32'h0);
      due_q.push_back(edge_cnt + LAT - 1);
      if (m_rd < 65535) m_rd++;
    end
    chk("rd_count", 64'(bus.rd_count), 64'(m_rd));
    chk("wr_count", 64'(bus.wr_count), 64'(m_wr));
    chk("err", 64'(bus.err), 64'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(1'b0, 1'b0, 0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 1'b0;
    exp_q.delete();
    due_q.delete();
    last_resp = '0;
    for (int i = 0; i < DEP; i++) mdl[i] = '0;
    m_err = 1'b0;
    m_rd = 0;
    m_wr = 0;
    #1;
    chk("rst_valid", 64'(bus.mem_resp_valid), 64'(0));
    chk("rst_data", 64'(bus.mem_resp_data), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    chk("rst_rd_count", 64'(bus.rd_count), 64'(0));
    chk("rst_wr_count", 64'(bus.wr_count), 64'(0));
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.mem_req_addr = '0;
    bus.mem_req_data = '0;
    do_reset();

    // Write then read back one beat
    req(1'b0, 1'b1, 5, 32'hDEADBEEF);
    req(1'b1, 1'b0, 5, 32'h0);
    idle(4);

    // Burst of writes then back-to-back reads
    for (int a = 0; a < 16; a++) req(1'b0, 1'b1, a, 32'(a + 100));
    for (int a = 0; a < 16; a++) req(1'b1, 1'b0, a, 32'h0);
    idle(4);
    chk("burst_err", 64'(bus.err), 64'(0));

    // Simultaneous read and write: write wins, read dropped
    req(1'b1, 1'b1, 7, 32'h55);
    idle(3);
    req(1'b1, 1'b0, 7, 32'h0);
    idle(4);

    // Out-of-range read and write
    do_reset();
    req(1'b0, 1'b1, 63, 32'h1234_5678);
    req(1'b1, 1'b0, 64, 32'h0);
    idle(3);
    req(1'b0, 1'b1, 100, 32'hCAFE_F00D);
    req(1'b1, 1'b0, 63, 32'h0);
    req(1'b1, 1'b0, 8191, 32'h0);
    idle(4);

    // Randomized traffic, including collisions and out-of-range addresses
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      req(r < 6, (r >= 4), int'($urandom_range(0, 70)), $urandom);
    end
    idle(4);

    // Reset with a read in flight
    req(1'b0, 1'b1, 9, 32'hA5A5_A5A5);
    req(1'b1, 1'b0, 9, 32'h0);
    do_reset();
    idle(4);
    req(1'b1, 1'b0, 9, 32'h0);
    idle(4);

    // Read-counter saturation
    do_reset();
    for (int i = 0; i < 65535; i++) req(1'b1, 1'b0, i % DEP, 32'h0);
    chk("rd_sat_reach", 64'(bus.rd_count), 64'(16'hFFFF));
    req(1'b1, 1'b0, 3, 32'h0);
    chk("rd_sat_hold", 64'(bus.rd_count), 64'(16'hFFFF));

    // Drain, bounded
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
    end
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
